// File: rtl/exe_unit_w6_pkg.sv
// Shared types and constants for the exe_unit_w6 execution unit and its two-requester scheduler.
package exe_unit_w6_pkg;

    typedef enum logic [1:0] {
        OP_SUB    = 2'b00,
        OP_CMP    = 2'b01,
        OP_SHIFT  = 2'b10,
        OP_BITSET = 2'b11
    } op_e;

    localparam int unsigned ST_ERR    = 0;
    localparam int unsigned ST_EVEN   = 1;
    localparam int unsigned ST_SINGLE = 2;
    localparam int unsigned ST_OVF    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } sched_state_e;

endpackage

// File: rtl/exe_unit_w6.sv
// SUB/CMP/SHIFT/BITSET unit with 4-bit status; result appears LAT clock edges after the operands.
module exe_unit_w6
    import exe_unit_w6_pkg::*;
#(
    parameter int unsigned BITS = 8,
    parameter int unsigned LAT  = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [BITS-1:0] i_a,
    input  logic [BITS-1:0] i_b,
    input  logic [1:0]      i_op,
    output logic [BITS-1:0] o_out,
    output logic [3:0]      o_status
);

    localparam logic [BITS-1:0] LIMIT = BITS'(BITS);

    logic [BITS-1:0]   res;
    logic [3:0]        st;
    logic [2*BITS-1:0] wide;
    logic              bad_idx;

    logic [BITS-1:0] out_q [LAT];
    logic [3:0]      st_q  [LAT];

    always_comb begin
        res     = '0;
        st      = '0;
        wide    = '0;
        // Shift amounts and bit indices beyond the word are flagged, not wrapped.
        bad_idx = (i_b >= LIMIT);
        unique case (op_e'(i_op))
            OP_SUB: begin
                res         = i_a - i_b;
                st[ST_OVF]  = (i_a < i_b);
            end
            OP_CMP: begin
                res[0] = (i_a == i_b);
                res[1] = (i_a < i_b);
                res[2] = (i_a > i_b);
            end
            OP_SHIFT: begin
                if (bad_idx) begin
                    st[ST_ERR] = 1'b1;
                end else begin
                    wide       = {{BITS{1'b0}}, i_a} << i_b;
                    res        = wide[BITS-1:0];
                    st[ST_OVF] = |wide[2*BITS-1:BITS];
                end
            end
            OP_BITSET: begin
                if (bad_idx) begin
                    st[ST_ERR] = 1'b1;
                    res        = i_a;
                end else begin
                    res = i_a | (BITS'(1) << i_b);
                end
            end
        endcase
        st[ST_EVEN]   = ~^res;
        st[ST_SINGLE] = $onehot(res);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < LAT; i++) begin
                out_q[i] <= '0;
                st_q[i]  <= '0;
            end
        end else begin
            out_q[0] <= res;
            st_q[0]  <= st;
            for (int i = 1; i < LAT; i++) begin
                out_q[i] <= out_q[i-1];
                st_q[i]  <= st_q[i-1];
            end
        end
    end

    assign o_out    = out_q[LAT-1];
    assign o_status = st_q[LAT-1];

endmodule

// File: rtl/exe_unit_w6_sched.sv
// Round-robin scheduler sharing one exe_unit_w6 between two valid/ready requesters,
// with a saturating count of error-flagged responses.
module exe_unit_w6_sched
    import exe_unit_w6_pkg::*;
#(
    parameter int unsigned BITS    = 8,
    parameter int unsigned EXE_LAT = 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_req_valid,
    output logic [1:0]        o_req_ready,
    input  logic [2*BITS-1:0] i_req_a,
    input  logic [2*BITS-1:0] i_req_b,
    input  logic [3:0]        i_req_op,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic              o_rsp_id,
    output logic [BITS-1:0]   o_rsp_out,
    output logic [3:0]        o_rsp_status,
    output logic              o_busy,
    input  logic              i_clr_cnt,
    output logic [CNT_W-1:0]  o_err_cnt
);

    localparam int unsigned CW = $clog2(EXE_LAT + 1);

    sched_state_e    state_q, state_d;
    logic            rr_q;
    logic [BITS-1:0] a_q, b_q;
    logic [1:0]      op_q;
    logic            id_q;
    logic [CW-1:0]   cnt_q;
    logic [BITS-1:0] rsp_out_q;
    logic [3:0]      rsp_status_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic            grant;
    logic            grant_vld;
    logic            accept;
    logic            rsp_hs;
    logic [BITS-1:0] exe_out;
    logic [3:0]      exe_status;

    always_comb begin
        grant     = rr_q;
        grant_vld = 1'b0;
        if (i_req_valid[rr_q]) begin
            grant     = rr_q;
            grant_vld = 1'b1;
        end else if (i_req_valid[~rr_q]) begin
            grant     = ~rr_q;
            grant_vld = 1'b1;
        end
    end

    assign accept      = (state_q == IDLE) && grant_vld;
    assign rsp_hs      = (state_q == RESP) && i_rsp_ready;
    assign o_req_ready = accept ? (2'b01 << grant) : 2'b00;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = RESP;
            RESP:    if (i_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            rr_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            cnt_q        <= '0;
            rsp_out_q    <= '0;
            rsp_status_q <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q   <= i_req_a[grant*BITS +: BITS];
                b_q   <= i_req_b[grant*BITS +: BITS];
                op_q  <= i_req_op[grant*2 +: 2];
                id_q  <= grant;
                // One extra edge beyond the unit latency lets the unit's output register settle.
                cnt_q <= CW'(EXE_LAT);
            end else if (state_q == WAIT) begin
                if (cnt_q == '0) begin
                    rsp_out_q    <= exe_out;
                    rsp_status_q <= exe_status;
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                end
            end
            if (rsp_hs) begin
                rr_q <= ~id_q;
            end
            if (i_clr_cnt) begin
                err_cnt_q <= '0;
            end else if (rsp_hs && rsp_status_q[ST_ERR] && !(&err_cnt_q)) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
        end
    end

    exe_unit_w6 #(
        .BITS (BITS),
        .LAT  (EXE_LAT)
    ) u_exe (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_a      (a_q),
        .i_b      (b_q),
        .i_op     (op_q),
        .o_out    (exe_out),
        .o_status (exe_status)
    );

    assign o_rsp_valid  = (state_q == RESP);
    assign o_rsp_id     = id_q;
    assign o_rsp_out    = rsp_out_q;
    assign o_rsp_status = rsp_status_q;
    assign o_busy       = (state_q != IDLE);
    assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_exe_unit_w6_sched.sv
// Directed self-checking bench for exe_unit_w6_sched with BITS=8, EXE_LAT=1.
module tb_exe_unit_w6_sched;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [7:0]  rsp_out;
    logic [3:0]  rsp_status;
    logic        busy;
    logic        clr_cnt;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    exe_unit_w6_sched #(
        .BITS    (8),
        .EXE_LAT (1),
        .CNT_W   (8)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .i_req_op     (req_op),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_id     (rsp_id),
        .o_rsp_out    (rsp_out),
        .o_rsp_status (rsp_status),
        .o_busy       (busy),
        .i_clr_cnt    (clr_cnt),
        .o_err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_req(input int r, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] op);
        req_a[r*8 +: 8]  = a;
        req_b[r*8 +: 8]  = b;
        req_op[r*2 +: 2] = op;
        req_valid[r]     = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input int r, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op);
        bit seen = 0;
        set_req(r, a, b, op);
        for (int k = 0; k < 20 && !seen; k++) begin
            #1;
            if (req_ready[r]) seen = 1;
            else @(negedge clk);
        end
        check("req_ready_seen", seen, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid[r] = 1'b0;
    endtask

    // Called at a negedge; completes the handshake when rsp_ready is high.
    task automatic wait_rsp(input string tag, input logic exp_id, input logic [7:0] exp_out,
                            input logic [3:0] exp_st);
        bit seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (rsp_valid) seen = 1;
            else @(negedge clk);
        end
        check({tag, "_valid"}, seen, 1);
        check({tag, "_id"}, rsp_id, exp_id);
        check({tag, "_out"}, rsp_out, exp_out);
        check({tag, "_status"}, rsp_status, exp_st);
        if (rsp_ready) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        clr_cnt   = 1'b0;
        do_reset();

        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 2'b00);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_rsp_out", rsp_out, 0);
        check("rst_rsp_status", rsp_status, 0);
        check("rst_rsp_id", rsp_id, 0);

        // 1: SUB 91-41, latency check edge by edge
        set_req(0, 8'd91, 8'd41, 2'b00);
        #1 check("t1_ready_e0", req_ready, 2'b01);
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("t1_valid_e0", rsp_valid, 0);
        check("t1_busy", busy, 1);
        @(posedge clk);
        @(negedge clk);
        check("t1_valid_e1", rsp_valid, 0);
        @(posedge clk);
        @(negedge clk);
        check("t1_valid_e2", rsp_valid, 1);
        wait_rsp("t1", 1'b0, 8'd50, 4'b0000);
        check("t1_idle", busy, 0);

        // 2: both valid from reset, req0 served first, then req1
        do_reset();
        set_req(0, 8'd5, 8'd7, 2'b01);
        set_req(1, 8'b0000_1001, 8'd1, 2'b10);
        #1 check("t2_ready_first", req_ready, 2'b01);
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        wait_rsp("t2_r0", 1'b0, 8'd2, 4'b0100);
        #1 check("t2_ready_second", req_ready, 2'b10);
        issue(1, 8'b0000_1001, 8'd1, 2'b10);
        wait_rsp("t2_r1", 1'b1, 8'd18, 4'b0010);

        // 3: SHIFT out of range flags ERR; counter increments on handshake, clear wins
        rsp_ready = 1'b0;
        issue(1, 8'b1100_0001, 8'b1000_0001, 2'b10);
        wait_rsp("t3a", 1'b1, 8'd0, 4'b0011);
        check("t3_cnt_before", err_cnt, 0);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t3_cnt_after", err_cnt, 1);
        rsp_ready = 1'b0;
        issue(1, 8'b1100_0001, 8'b1000_0001, 2'b10);
        wait_rsp("t3b", 1'b1, 8'd0, 4'b0011);
        rsp_ready = 1'b1;
        clr_cnt   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_cnt = 1'b0;
        check("t3_cnt_clr", err_cnt, 0);

        // 4: response back-pressure holds outputs and blocks new grants
        rsp_ready = 1'b0;
        issue(0, 8'd10, 8'd20, 2'b00);
        wait_rsp("t4", 1'b0, 8'd246, 4'b1010);
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t4_hold_valid", rsp_valid, 1);
            check("t4_hold_out", rsp_out, 8'd246);
            check("t4_hold_ready", req_ready, 2'b00);
            check("t4_hold_busy", busy, 1);
            @(negedge clk);
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t4_released", busy, 0);

        // 5: async reset during WAIT drops the command
        issue(0, 8'h55, 8'b1000_0001, 2'b11);
        wait_rsp("t5_err", 1'b0, 8'h55, 4'b0011);
        check("t5_cnt_pre", err_cnt, 1);
        issue(0, 8'h00, 8'd3, 2'b11);
        check("t5_in_wait", busy, 1);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_valid", rsp_valid, 0);
        check("t5_rst_out", rsp_out, 0);
        check("t5_rst_status", rsp_status, 0);
        check("t5_rst_cnt", err_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        issue(0, 8'h00, 8'd3, 2'b11);
        wait_rsp("t5_after", 1'b0, 8'd8, 4'b0100);

        // 6: counter saturation
        for (int i = 0; i < 255; i++) begin
            issue(0, 8'h00, 8'b1000_0001, 2'b11);
            wait_rsp("t6", 1'b0, 8'd0, 4'b0011);
            if (i == 253) check("t6_cnt_fe", err_cnt, 8'hFE);
        end
        check("t6_cnt_ff", err_cnt, 8'hFF);
        issue(0, 8'h00, 8'b1000_0001, 2'b11);
        wait_rsp("t6_sat", 1'b0, 8'd0, 4'b0011);
        check("t6_cnt_sat", err_cnt, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
